// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/ready/done operand and result bundle for serial_adder
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder slice per clock, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] s_msb;

  assign s_bit = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign c_bit = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

  // Places the new sum bit at the MSB without a zero-width replication when WIDTH=1.
  always_comb begin
    s_msb = '0;
    s_msb[WIDTH-1] = s_bit;
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = c_bit;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = (s_sr_q >> 1) | s_msb;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          sum_d   = (s_sr_q >> 1) | s_msb;
          cout_d  = c_bit;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake outputs decode straight from the state register.
  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] prev8 = '0;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    vectors++;
    if (bus8.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue8_ready: got %b expected 1", bus8.ready);
    end
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + {8'b0, c});
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // Entered at the negedge after the accepting edge; leaves at the negedge where ready returns.
  task automatic finish8(output int dcyc);
    int busy_n = 0;
    bit got = 0;
    bit hold_ok = 1;
    logic [8:0] exp;
    dcyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus8.busy === 1'b1) begin
        busy_n++;
        if ({bus8.cout, bus8.sum} !== prev8) hold_ok = 0;
      end else if (bus8.done === 1'b1) begin
        got = 1;
      end
      if (!got) @(negedge clk);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL done8_timeout: got no done expected done within 20 cycles");
      return;
    end
    dcyc = cyc;
    exp = q8.pop_front();
    vectors++;
    if ({bus8.cout, bus8.sum} !== exp) begin
      miscompares++;
      $display("FAIL result8: got %h expected %h", {bus8.cout, bus8.sum}, exp);
    end
    prev8 = exp;
    vectors++;
    if (busy_n != 8) begin
      miscompares++;
      $display("FAIL busy_cycles8: got %0d expected 8", busy_n);
    end
    vectors++;
    if (!hold_ok) begin
      miscompares++;
      $display("FAIL sum_hold8: got changing result expected stable during RUN");
    end
    @(negedge clk);
    vectors++;
    if ({bus8.done, bus8.busy, bus8.ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL after_done8: got done/busy/ready %b expected 001", {bus8.done, bus8.busy, bus8.ready});
    end
  endtask

  task automatic test_reset();
    bus8.start = 0; bus8.a = '0; bus8.b = '0; bus8.cin = 0;
    bus1.start = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {3'b100, 9'h000}) begin
      miscompares++;
      $display("FAIL reset8: got %b expected 100000000000", {bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum});
    end
    vectors++;
    if ({bus1.ready, bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset1: got %b expected 10000", {bus1.ready, bus1.busy, bus1.done, bus1.cout, bus1.sum});
    end
    rst = 1'b0;
    prev8 = '0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int d;
    issue8(8'h00, 8'h00, 1'b0);
    finish8(d);
    issue8(8'hFF, 8'h01, 1'b0);
    finish8(d);
  endtask

  task automatic test_start_held();
    int d;
    issue8(8'hA5, 8'h5A, 1'b1);
    bus8.start = 1'b1;
    bus8.a = 8'h12;
    finish8(d);
    q8.push_back({1'b0, 8'h12} + {1'b0, 8'h5A} + 9'd1);
    @(negedge clk);
    bus8.start = 1'b0;
    vectors++;
    if (bus8.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL held_restart: got busy %b expected 1", bus8.busy);
    end
    finish8(d);
  endtask

  task automatic test_reset_mid_run();
    int d;
    bit saw_done = 0;
    issue8(8'h3C, 8'h0F, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {3'b100, 9'h000}) begin
      miscompares++;
      $display("FAIL reset_mid_run: got %b expected 100000000000", {bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum});
    end
    void'(q8.pop_front());
    prev8 = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus8.done !== 1'b0) saw_done = 1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL no_done_after_abort: got done pulse expected none");
    end
    issue8(8'h01, 8'h01, 1'b0);
    finish8(d);
  endtask

  task automatic test_width1();
    logic [1:0] exp;
    logic       a, b, c;
    int         n;
    for (int v = 0; v < 8; v++) begin
      a = v[0]; b = v[1]; c = v[2];
      vectors++;
      if (bus1.ready !== 1'b1) begin
        miscompares++;
        $display("FAIL w1_ready: got %b expected 1", bus1.ready);
      end
      bus1.a = a; bus1.b = b; bus1.cin = c; bus1.start = 1'b1;
      q1.push_back({1'b0, a} + {1'b0, b} + {1'b0, c});
      @(negedge clk);
      bus1.start = 1'b0;
      n = 0;
      while (bus1.done !== 1'b1 && n < 6) begin
        @(negedge clk);
        n++;
      end
      exp = q1.pop_front();
      vectors++;
      if (n != 1) begin
        miscompares++;
        $display("FAIL w1_latency: got %0d expected 1 edges after accept", n);
      end
      vectors++;
      if ({bus1.cout, bus1.sum} !== exp) begin
        miscompares++;
        $display("FAIL w1_result abc=%b%b%b: got %b expected %b", a, b, c, {bus1.cout, bus1.sum}, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    int last = 0;
    logic [7:0] a, b;
    logic c;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      issue8(a, b, c);
      finish8(d);
      if (i > 0) begin
        vectors++;
        if (d - last != 10) begin
          miscompares++;
          $display("FAIL b2b_spacing op%0d: got %0d expected 10", i, d - last);
        end
      end
      last = d;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_held();
    test_reset_mid_run();
    test_width1();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
